// File: rtl/motor_ramp_if.sv
// Software command channel for the motor ramp controller: a valid/ready
// handshake that carries a requested duty code and direction.
interface motor_ramp_if;
    logic       sw_valid;
    logic [7:0] sw_duty;
    logic       sw_dir;
    logic       sw_ready;

    modport master (
        output sw_valid,
        output sw_duty,
        output sw_dir,
        input  sw_ready
    );

    modport slave (
        input  sw_valid,
        input  sw_duty,
        input  sw_dir,
        output sw_ready
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Motor ramp controller: sequences duty/direction/enable for the drive PWM.
// Duty slews toward a target once per prescaler tick. Direction changes and
// stops always pass through a ramp down to MIN_DUTY. A bumper hit overrides
// software with ramp-down, reverse back-off and return to idle.
module motor_ramp_ctrl #(
    parameter int STEP_DIV      = 100000,
    parameter int STEP          = 4,
    parameter int MIN_DUTY      = 102,
    parameter int MAX_DUTY      = 230,
    parameter int BACKOFF_TICKS = 8
) (
    input  logic              clk,
    input  logic              rst,
    motor_ramp_if.slave       sw_bus,
    input  logic              bump_hit_i,
    output logic [7:0]        duty_o,
    output logic              dir_o,
    output logic              motor_en_o,
    output logic [1:0]        state_o
);

    localparam int              PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(STEP_DIV - 1);
    localparam int              CW       = $clog2(BACKOFF_TICKS + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(BACKOFF_TICKS);
    localparam logic [7:0]      MIN_D    = 8'(MIN_DUTY);
    localparam logic [7:0]      MAX_D    = 8'(MAX_DUTY);
    localparam logic [8:0]      STEP_W   = 9'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_STOP    = 2'b10,
        ST_BACKOFF = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'b00,
        PEND_STOP = 2'b01,
        PEND_REV  = 2'b10,
        PEND_BUMP = 2'b11
    } pend_e;

    // Nonzero requests are limited to the band the motor actually turns in.
    function automatic logic [7:0] clamp_duty(input logic [7:0] d);
        if (d < MIN_D) begin
            return MIN_D;
        end else if (d > MAX_D) begin
            return MAX_D;
        end else begin
            return d;
        end
    endfunction

    // One ramp step toward tgt; 9-bit arithmetic so no step can wrap or overshoot.
    function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] cur_w;
        logic [8:0] tgt_w;
        logic [8:0] res_w;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        if (cur_w < tgt_w) begin
            res_w = ((cur_w + STEP_W) < tgt_w) ? (cur_w + STEP_W) : tgt_w;
        end else if (cur_w > tgt_w) begin
            res_w = (cur_w > (tgt_w + STEP_W)) ? (cur_w - STEP_W) : tgt_w;
        end else begin
            res_w = cur_w;
        end
        return res_w[7:0];
    endfunction

    state_e         state_q, state_d;
    pend_e          pend_q, pend_d;
    logic [7:0]     duty_q, duty_d;
    logic           dir_q, dir_d;
    logic           en_q, en_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [7:0]     target_q, target_d;
    logic [7:0]     pend_tgt_q, pend_tgt_d;
    logic           pend_dir_q, pend_dir_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           tick_s;
    logic           sw_ready_s;
    logic           accept_s;
    logic [7:0]     cmd_tgt_s;
    logic [7:0]     ramp_tgt_s;

    assign tick_s     = (pre_q == PRE_LAST);
    assign sw_ready_s = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !bump_hit_i;
    assign accept_s   = sw_bus.sw_valid && sw_ready_s;
    assign cmd_tgt_s  = clamp_duty(sw_bus.sw_duty);
    // Only RUN chases the software target; every other state settles at MIN_DUTY.
    assign ramp_tgt_s = (state_q == ST_RUN) ? target_q : MIN_D;
    assign pre_d      = tick_s ? '0 : (pre_q + PW'(1));

    assign sw_bus.sw_ready = sw_ready_s;
    assign duty_o          = duty_q;
    assign dir_o           = dir_q;
    assign motor_en_o      = en_q;
    assign state_o         = state_q;

    // State, output and prescaler registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= PEND_NONE;
            duty_q     <= MIN_D;
            dir_q      <= 1'b0;
            en_q       <= 1'b0;
            pre_q      <= '0;
            target_q   <= MIN_D;
            pend_tgt_q <= MIN_D;
            pend_dir_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            en_q       <= en_d;
            pre_q      <= pre_d;
            target_q   <= target_d;
            pend_tgt_q <= pend_tgt_d;
            pend_dir_q <= pend_dir_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: command capture, bump override, stop/back-off sequencing and ramp.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        dir_d      = dir_q;
        en_d       = en_q;
        target_d   = target_q;
        pend_tgt_d = pend_tgt_q;
        pend_dir_d = pend_dir_q;
        cnt_d      = cnt_q;
        // The ramp always uses the target in force before this cycle's transition.
        duty_d     = tick_s ? ramp_step(duty_q, ramp_tgt_s) : duty_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s && (sw_bus.sw_duty != 8'd0)) begin
                    dir_d    = sw_bus.sw_dir;
                    target_d = cmd_tgt_s;
                    en_d     = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (bump_hit_i) begin
                    pend_d  = PEND_BUMP;
                    state_d = ST_STOP;
                end else if (accept_s) begin
                    if (sw_bus.sw_duty == 8'd0) begin
                        pend_d  = PEND_STOP;
                        state_d = ST_STOP;
                    end else if (sw_bus.sw_dir != dir_q) begin
                        pend_d     = PEND_REV;
                        pend_tgt_d = cmd_tgt_s;
                        pend_dir_d = sw_bus.sw_dir;
                        state_d    = ST_STOP;
                    end else begin
                        target_d = cmd_tgt_s;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_STOP: begin
                if (bump_hit_i) begin
                    pend_d = PEND_BUMP;
                end else if (tick_s && (duty_q == MIN_D)) begin
                    pend_d = PEND_NONE;
                    case (pend_q)
                        PEND_REV: begin
                            dir_d    = pend_dir_q;
                            target_d = pend_tgt_q;
                            state_d  = ST_RUN;
                        end
                        PEND_BUMP: begin
                            dir_d   = ~dir_q;
                            cnt_d   = CNT_INIT;
                            state_d = ST_BACKOFF;
                        end
                        default: begin
                            en_d    = 1'b0;
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_STOP;
                end
            end

            ST_BACKOFF: begin
                if (tick_s) begin
                    if (cnt_q <= CW'(1)) begin
                        cnt_d   = '0;
                        en_d    = 1'b0;
                        dir_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    state_d = ST_BACKOFF;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pend_d  = PEND_NONE;
                en_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed self-checking bench for motor_ramp_ctrl with a fast prescaler.
module tb_motor_ramp_ctrl;

    localparam int STEP_DIV = 4;
    localparam int STEP     = 4;
    localparam int MIN_D    = 102;
    localparam int MAX_D    = 230;
    localparam int BO_TICKS = 3;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STOP = 2;
    localparam int S_BO   = 3;

    logic       clk;
    logic       rst;
    logic       bump_hit;
    logic [7:0] duty;
    logic       dir;
    logic       motor_en;
    logic [1:0] state;

    int checks_cnt;
    int errors_cnt;

    motor_ramp_if u_if ();

    motor_ramp_ctrl #(
        .STEP_DIV      (STEP_DIV),
        .STEP          (STEP),
        .MIN_DUTY      (MIN_D),
        .MAX_DUTY      (MAX_D),
        .BACKOFF_TICKS (BO_TICKS)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sw_bus     (u_if.slave),
        .bump_hit_i (bump_hit),
        .duty_o     (duty),
        .dir_o      (dir),
        .motor_en_o (motor_en),
        .state_o    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one command (optionally with a bump) for exactly one rising edge.
    task automatic send_cmd(input string tag, input int d, input int dr, input int bump, input int exp_ready);
        @(negedge clk);
        u_if.sw_valid = 1'b1;
        u_if.sw_duty  = 8'(d);
        u_if.sw_dir   = dr[0];
        bump_hit      = bump[0];
        #1;
        chk_eq({tag, ".ready"}, int'(u_if.sw_ready), exp_ready);
        @(posedge clk);
        #1;
        u_if.sw_valid = 1'b0;
        bump_hit      = 1'b0;
    endtask

    // Follow a ramp to tgt: every step must be STEP (or land on tgt), one step per
    // STEP_DIV cycles, and the direction must not move while ramping.
    task automatic wait_duty(input string tag, input int tgt, input int exp_steps);
        int  prev;
        int  prev_dir;
        int  steps;
        int  bad;
        int  gap;
        int  gap_bad;
        int  flips;
        int  budget;
        int  want;
        bit  done;
        prev     = int'(duty);
        prev_dir = int'(dir);
        steps    = 0;
        bad      = 0;
        gap      = 0;
        gap_bad  = 0;
        flips    = 0;
        done     = (prev == tgt);
        budget   = (exp_steps + 3) * STEP_DIV;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            gap++;
            if (int'(duty) != prev) begin
                steps++;
                if (prev < tgt) want = (prev + STEP < tgt) ? prev + STEP : tgt;
                else            want = (prev - STEP > tgt) ? prev - STEP : tgt;
                if (int'(duty) != want) bad++;
                if (steps > 1 && gap != STEP_DIV) gap_bad++;
                gap  = 0;
                prev = int'(duty);
            end
            if (int'(dir) != prev_dir) flips++;
            if (prev == tgt) done = 1'b1;
        end
        chk_eq({tag, ".reached"},  int'(done), 1);
        chk_eq({tag, ".steps"},    steps, exp_steps);
        chk_eq({tag, ".stepsize"}, bad, 0);
        chk_eq({tag, ".steprate"}, gap_bad, 0);
        chk_eq({tag, ".dirflip"},  flips, 0);
    endtask

    task automatic wait_state(input string tag, input int st, input int budget);
        bit seen;
        seen = (int'(state) == st);
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (int'(state) == st) seen = 1'b1;
        end
        chk_eq({tag, ".state"}, int'(state), st);
    endtask

    initial begin
        int k;
        int n;
        checks_cnt    = 0;
        errors_cnt    = 0;
        rst           = 1'b1;
        bump_hit      = 1'b0;
        u_if.sw_valid = 1'b0;
        u_if.sw_duty  = 8'd0;
        u_if.sw_dir   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk_eq("rst.state", int'(state), S_IDLE);
        chk_eq("rst.duty",  int'(duty), MIN_D);
        chk_eq("rst.dir",   int'(dir), 0);
        chk_eq("rst.en",    int'(motor_en), 0);
        rst = 1'b0;

        // 1: start forward at 200
        send_cmd("t1.cmd", 200, 0, 0, 1);
        chk_eq("t1.state", int'(state), S_RUN);
        chk_eq("t1.en",    int'(motor_en), 1);
        chk_eq("t1.dir",   int'(dir), 0);
        wait_duty("t1.up", 200, 25);
        repeat (3 * STEP_DIV) @(negedge clk);
        chk_eq("t1.hold", int'(duty), 200);

        // 2: clamping at both ends
        send_cmd("t2.hi", 250, 0, 0, 1);
        chk_eq("t2.state", int'(state), S_RUN);
        wait_duty("t2.up", 230, 8);
        send_cmd("t2.lo", 50, 0, 0, 1);
        wait_duty("t2.down", 102, 32);
        chk_eq("t2.state2", int'(state), S_RUN);
        chk_eq("t2.en",     int'(motor_en), 1);

        // 3: reversal passes through MIN_DUTY
        send_cmd("t3.fwd", 200, 0, 0, 1);
        wait_duty("t3.up", 200, 25);
        send_cmd("t3.rev", 150, 1, 0, 1);
        chk_eq("t3.stop",  int'(state), S_STOP);
        chk_eq("t3.ready", int'(u_if.sw_ready), 0);
        wait_duty("t3.fall", 102, 25);
        chk_eq("t3.still", int'(state), S_STOP);
        wait_state("t3.run", S_RUN, 2 * STEP_DIV + 2);
        chk_eq("t3.dir",   int'(dir), 1);
        chk_eq("t3.min",   int'(duty), MIN_D);
        wait_duty("t3.rise", 150, 12);

        // 4: bump together with a command
        send_cmd("t4.cmd", 180, 1, 0, 1);
        wait_duty("t4.up", 180, 8);
        send_cmd("t4.bump", 220, 1, 1, 0);
        chk_eq("t4.stop", int'(state), S_STOP);
        wait_duty("t4.fall", 102, 20);
        wait_state("t4.bo", S_BO, 2 * STEP_DIV + 2);
        chk_eq("t4.bodir",  int'(dir), 0);
        chk_eq("t4.boduty", int'(duty), MIN_D);
        chk_eq("t4.boen",   int'(motor_en), 1);
        n = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (int'(state) == S_BO) n++;
            else break;
        end
        chk_eq("t4.bolen", n, BO_TICKS * STEP_DIV);
        chk_eq("t4.idle",  int'(state), S_IDLE);
        chk_eq("t4.en",    int'(motor_en), 0);
        chk_eq("t4.dir",   int'(dir), 0);
        chk_eq("t4.duty",  int'(duty), MIN_D);

        // 5: asynchronous reset mid-ramp
        send_cmd("t5.cmd", 150, 1, 0, 1);
        wait_duty("t5.up", 150, 12);
        send_cmd("t5.more", 230, 1, 0, 1);
        repeat (6) @(negedge clk);
        chk_eq("t5.moving", int'(duty > 8'd150), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_eq("t5.state", int'(state), S_IDLE);
        chk_eq("t5.duty",  int'(duty), MIN_D);
        chk_eq("t5.dir",   int'(dir), 0);
        chk_eq("t5.en",    int'(motor_en), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 6: prescaler restarts from zero, then stop command
        send_cmd("t6.cmd", 200, 0, 0, 1);
        k = 0;
        for (int c = 0; c < 3 * STEP_DIV; c++) begin
            @(negedge clk);
            k++;
            if (int'(duty) != MIN_D) break;
        end
        chk_eq("t6.first", k, 3);
        chk_eq("t6.step1", int'(duty), 106);
        wait_duty("t6.up", 200, 24);
        send_cmd("t6.zero", 0, 0, 0, 1);
        chk_eq("t6.stop", int'(state), S_STOP);
        wait_duty("t6.fall", 102, 25);
        wait_state("t6.idle", S_IDLE, 2 * STEP_DIV + 2);
        chk_eq("t6.en",  int'(motor_en), 0);
        chk_eq("t6.dir", int'(dir), 0);
        send_cmd("t6.zero2", 0, 1, 0, 1);
        repeat (2 * STEP_DIV) @(negedge clk);
        chk_eq("t6.idle2", int'(state), S_IDLE);
        chk_eq("t6.en2",   int'(motor_en), 0);
        chk_eq("t6.dir2",  int'(dir), 0);
        chk_eq("t6.duty2", int'(duty), MIN_D);

        // Bump while idle is ignored
        @(negedge clk);
        bump_hit = 1'b1;
        @(negedge clk);
        bump_hit = 1'b0;
        repeat (2 * STEP_DIV) @(negedge clk);
        chk_eq("idle.bump", int'(state), S_IDLE);
        chk_eq("idle.en",   int'(motor_en), 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
